// File: rtl/servo_slew_sequencer_if.sv
// Command channel between the lock/safe controller and the servo slew sequencer.
// The controller drives target positions and abort requests; the sequencer answers with ready.
interface servo_slew_sequencer_if;
  logic       cmd_valid;
  logic [7:0] cmd_pos;
  logic       cmd_ready;
  logic       abort;

  modport master (
    output cmd_valid,
    output cmd_pos,
    output abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_pos,
    input  abort,
    output cmd_ready
  );
endinterface

// File: rtl/servo_slew_sequencer.sv
// Servo slew sequencer: ramps the PWM position toward a commanded target by at most
// STEP counts per servo frame, holds the target for SETTLE_FRAMES frames and pulses done.
// The position only moves on frame boundaries, which keeps every PWM pulse glitch-free.
module servo_slew_sequencer #(
  parameter int unsigned FRAME_CYCLES  = 1048576,
  parameter int unsigned STEP          = 4,
  parameter int unsigned SETTLE_FRAMES = 8,
  parameter logic [7:0]  RESET_POS     = 8'd128
) (
  input  logic                        clk,
  input  logic                        rst,
  servo_slew_sequencer_if.slave       cmd,
  output logic [7:0]                  position,
  output logic                        busy,
  output logic                        done,
  output logic                        frame_tick
);

  localparam int unsigned FRAME_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int unsigned SETTLE_W = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
  localparam logic [FRAME_W-1:0]  FRAME_LAST  = FRAME_W'(FRAME_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_FRAMES - 1);
  localparam logic [7:0]          STEP_POS    = 8'(STEP);
  localparam logic [8:0]          STEP_MAG    = 9'(STEP);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    SETTLE
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [FRAME_W-1:0]    frame_ctr;
  logic [SETTLE_W-1:0]   settle_ctr;
  logic [SETTLE_W-1:0]   settle_next;
  logic [7:0]            target;
  logic [7:0]            target_next;
  logic [7:0]            position_next;
  logic                  done_next;
  logic signed [8:0]     diff;
  logic [8:0]            diff_mag;

  // Free-running frame counter; only rst touches it so it stays in phase with the PWM driver.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_ctr <= '0;
    end else if (frame_ctr == FRAME_LAST) begin
      frame_ctr <= '0;
    end else begin
      frame_ctr <= frame_ctr + FRAME_W'(1);
    end
  end

  assign frame_tick    = (frame_ctr == FRAME_LAST);
  assign busy          = (state != IDLE);
  assign cmd.cmd_ready = (state == IDLE);

  // Signed distance to the target and its magnitude for the clamp decision.
  always_comb begin
    diff     = $signed({1'b0, target}) - $signed({1'b0, position});
    diff_mag = diff[8] ? $unsigned(-diff) : $unsigned(diff);
  end

  // Sequencer state register together with the position, target, settle count and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      position   <= RESET_POS;
      target     <= RESET_POS;
      settle_ctr <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      position   <= position_next;
      target     <= target_next;
      settle_ctr <= settle_next;
      done       <= done_next;
    end
  end

  // Next-state logic: abort wins over a frame tick; the final step clamps onto the target.
  always_comb begin
    state_next    = state;
    position_next = position;
    target_next   = target;
    settle_next   = settle_ctr;
    done_next     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd.cmd_valid) begin
          target_next = cmd.cmd_pos;
          state_next  = MOVE;
        end
      end
      MOVE: begin
        if (cmd.abort) begin
          state_next = IDLE;
        end else if (frame_tick) begin
          if (diff_mag <= STEP_MAG) begin
            position_next = target;
            settle_next   = '0;
            state_next    = SETTLE;
          end else if (!diff[8]) begin
            position_next = position + STEP_POS;
          end else begin
            position_next = position - STEP_POS;
          end
        end
      end
      SETTLE: begin
        if (cmd.abort) begin
          state_next = IDLE;
        end else if (frame_tick) begin
          if (settle_ctr == SETTLE_LAST) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            settle_next = settle_ctr + SETTLE_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
